// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter definitions: frame geometry, default baud divisor and FSM state type.
package common;

   localparam int NUM_DATA_BITS    = 8;
   localparam int BAUD_COUNT_CHECK = 868;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } uart_tx_state_type;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes queued for the serializer.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == DEPTH_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr_q];
   // Requests against a full or empty buffer are dropped rather than corrupting state.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serializer FSM.
module uart_tx
   import common::*;
#(
   parameter int CLKS_PER_BIT = BAUD_COUNT_CHECK,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_DATA_BITS-1:0] tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic                     tx,
   output logic                     busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(NUM_DATA_BITS);
   localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT  = IW'(NUM_DATA_BITS - 1);

   uart_tx_state_type          state_q, state_d;
   logic [CW-1:0]              bit_cnt_q, bit_cnt_d;
   logic [IW-1:0]              bit_idx_q, bit_idx_d;
   logic [NUM_DATA_BITS-1:0]   data_q, data_d;
   logic                       tx_q, tx_d;
   logic                       bit_done;

   logic [NUM_DATA_BITS-1:0]   fifo_rdata;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       fifo_pop;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   uart_tx_fifo #(
      .WIDTH (NUM_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_valid),
      .wdata (tx_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tx_ready = !fifo_full;
   assign tx       = tx_q;
   assign busy     = (state_q != TX_IDLE) || (fifo_count != '0);
   assign bit_done = (bit_cnt_q == LAST_TICK);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q + 1'b1;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      fifo_pop  = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            bit_cnt_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               data_d   = fifo_rdata;
               state_d  = TX_START;
            end
         end
         TX_START: begin
            if (bit_done) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = TX_DATA;
            end
         end
         TX_DATA: begin
            if (bit_done) begin
               bit_cnt_d = '0;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = TX_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         TX_STOP: begin
            // Chain straight into the next frame when a byte is waiting.
            if (bit_done) begin
               bit_cnt_d = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  data_d   = fifo_rdata;
                  state_d  = TX_START;
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // Line level is registered from the current state, so it trails the FSM by one cycle.
   always_comb begin
      unique case (state_q)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = data_q[bit_idx_q];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= TX_IDLE;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         data_q    <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, directed corner sequences, timing model, scoreboard.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       tx;
   logic       busy;

   always #5 clk = ~clk;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .busy     (busy)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: each accepted byte owns a frame whose first low cycle follows
   // the edge max(accept+2, previous frame start + FRAME).
   int         fs[$];
   logic [7:0] fd[$];
   logic [7:0] sb_exp[$];
   int         last_start = -1000;
   int         epoch = 0;
   bit         live = 0;
   bit         m_ready = 1'b1;
   bit         m_busy = 1'b0;
   bit         m_tx = 1'b1;
   int         m_cnt, m_s, m_j;
   logic [7:0] m_b;
   int         acc_at [256];

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         fs.delete();
         fd.delete();
         sb_exp.delete();
         last_start = -1000;
         epoch++;
         live = 1;
      end else if (tx_valid && m_ready) begin
         m_s = cyc + 2;
         if (last_start + FRAME > m_s) m_s = last_start + FRAME;
         fs.push_back(m_s);
         fd.push_back(tx_data);
         sb_exp.push_back(tx_data);
         acc_at[tx_data] = cyc;
         last_start = m_s;
      end
      while (fs.size() > 0 && fs[0] + FRAME < cyc - 1) begin
         void'(fs.pop_front());
         void'(fd.pop_front());
      end
      m_cnt = 0;
      m_busy = 1'b0;
      m_tx = 1'b1;
      foreach (fs[i]) begin
         if (fs[i] - 1 > cyc) m_cnt++;
         if (cyc < fs[i] + FRAME - 1) m_busy = 1'b1;
         if (cyc >= fs[i] && cyc < fs[i] + FRAME) begin
            m_j = (cyc - fs[i]) / CPB;
            m_b = fd[i];
            if (m_j == 0)      m_tx = 1'b0;
            else if (m_j == 9) m_tx = 1'b1;
            else               m_tx = m_b[m_j-1];
         end
      end
      m_ready = (m_cnt < DEPTH);
      #1;
      if (live) begin
         check("model_tx", tx, m_tx);
         check("model_ready", tx_ready, m_ready);
         check("model_busy", busy, m_busy);
      end
   end

   // Scoreboard: decode the line mid-bit and match against accepted bytes.
   int         mon_ep;
   bit         mon_ok;
   logic [7:0] mon_b;

   always begin
      @(posedge clk);
      #3;
      if (tx === 1'b0) begin
         mon_ep = epoch;
         mon_ok = 1'b1;
         repeat (CPB / 2) @(posedge clk);
         #3;
         if (tx !== 1'b0) mon_ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #3;
            mon_b[i] = tx;
         end
         repeat (CPB) @(posedge clk);
         #3;
         if (tx !== 1'b1) mon_ok = 1'b0;
         if (mon_ep == epoch) begin
            check("sb_have_expected", 32'(sb_exp.size() != 0), 32'd1);
            if (sb_exp.size() != 0) check("sb_byte", mon_b, sb_exp.pop_front());
            check("sb_framing", mon_ok, 1);
         end
      end
   end

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;  // bit 9 goes on the line first
   } vec_t;

   vec_t vecs [8];
   bit   exp_bits[$];

   task automatic at(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic add_frame(input logic [9:0] f);
      for (int j = 9; j >= 0; j--) exp_bits.push_back(f[j]);
   endtask

   task automatic check_bits(input int e, input int lo, input int hi, input string name);
      for (int i = lo; i <= hi; i++) begin
         at(e + 2 + CPB * i + CPB / 2);
         check(name, tx, exp_bits[i]);
      end
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy !== 1'b0 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("idle_timeout", 32'(g < 2000), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   int e;
   int guard;
   bit saw_low;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      foreach (acc_at[i]) acc_at[i] = -1;
      vecs[0] = '{8'h55, 10'b0101010101};
      vecs[1] = '{8'hA5, 10'b0101001011};
      vecs[2] = '{8'h3C, 10'b0001111001};
      vecs[3] = '{8'h0F, 10'b0111100001};
      vecs[4] = '{8'h00, 10'b0000000001};
      vecs[5] = '{8'hFF, 10'b0111111111};
      vecs[6] = '{8'h80, 10'b0000000011};
      vecs[7] = '{8'h01, 10'b0100000001};

      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_ready", tx_ready, 1);
      check("reset_busy", busy, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Single frames from idle.
      foreach (vecs[v]) begin
         @(negedge clk);
         tx_valid = 1'b1;
         tx_data  = vecs[v].data;
         e = cyc + 1;
         @(negedge clk);
         tx_valid = 1'b0;
         tx_data  = ~vecs[v].data;
         at(e + 1);
         check("pre_start_high", tx, 1);
         exp_bits.delete();
         add_frame(vecs[v].frame);
         check_bits(e, 0, 9, "frame_bit");
         at(e + 40);
         check("busy_last", busy, 1);
         at(e + 41);
         check("busy_drop", busy, 0);
         check("idle_high", tx, 1);
         wait_idle();
      end

      // Two consecutive pushes: contiguous 80-cycle transmission.
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      e = cyc + 1;
      @(negedge clk);
      tx_data = 8'h3C;
      @(negedge clk);
      tx_valid = 1'b0;
      exp_bits.delete();
      add_frame(vecs[1].frame);
      add_frame(vecs[2].frame);
      check_bits(e, 0, 19, "b2b_bit");
      at(e + 80);
      check("b2b_busy_last", busy, 1);
      at(e + 81);
      check("b2b_busy_drop", busy, 0);
      wait_idle();

      // Hold tx_valid through a full buffer.
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      e = cyc + 1;
      @(negedge clk);
      for (int v = 1; v <= 5; v++) begin
         tx_data = 8'(v);
         if (v == 5) check("full_ready_low", tx_ready, 0);
         guard = 0;
         while (tx_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         check("hold_timeout", 32'(guard < 200), 32'd1);
         @(negedge clk);
      end
      tx_valid = 1'b0;
      check("acc_01", acc_at[1], e + 1);
      check("acc_04", acc_at[4], e + 4);
      check("acc_05", acc_at[5], e + 42);
      wait_idle();

      // Push on the same edge the FSM pops at the end of a stop bit.
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      e = cyc + 1;
      @(negedge clk);
      tx_data = 8'h80;
      @(negedge clk);
      tx_valid = 1'b0;
      exp_bits.delete();
      add_frame(vecs[5].frame);
      add_frame(vecs[6].frame);
      add_frame(vecs[4].frame);
      check_bits(e, 0, 9, "simul_bit");
      at(e + 40);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      @(negedge clk);
      tx_valid = 1'b0;
      check("simul_ready", tx_ready, 1);
      check("simul_acc", acc_at[0], e + 41);
      check_bits(e, 10, 29, "simul_bit");
      wait_idle();

      // Reset during data bit 3 of 0x0F with two bytes buffered and a push pending.
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h0F;
      e = cyc + 1;
      @(negedge clk);
      tx_data = 8'h11;
      @(negedge clk);
      tx_data = 8'h22;
      @(negedge clk);
      tx_valid = 1'b0;
      at(e + 18);
      check("pre_reset_bit3", tx, 1);
      @(negedge clk);
      reset    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h99;
      @(negedge clk);
      reset    = 1'b0;
      tx_valid = 1'b0;
      check("abort_tx", tx, 1);
      check("abort_ready", tx_ready, 1);
      check("abort_busy", busy, 0);
      saw_low = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
      end
      check("abort_quiet", saw_low, 0);

      // Random traffic: light load, then heavy load that fills the buffer.
      for (int k = 0; k < 800; k++) begin
         @(negedge clk);
         tx_valid = (k < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0);
         tx_data  = 8'($urandom);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      wait_idle();
      repeat (50) @(negedge clk);
      check("sb_drain", sb_exp.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default BAUD_COUNT_CHECK (868 at 100 MHz / 115200): clock cycles per serial bit; legal range >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: byte buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  NUM_DATA_BITS (8)  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data holds a byte offered for transmission.
REQ-007 SHALL have port tx_ready  output  1  buffer can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line; idle high.
REQ-009 SHALL have port busy  output  1  frame in progress or buffer non-empty.

Function
REQ-010 SHALL accept a byte on every rising edge where tx_valid && tx_ready; tx_ready = !full, combinational from the buffer count only (no dependence on tx_valid).
REQ-011 SHALL buffer bytes FIFO-ordered; transmission order equals acceptance order.
REQ-012 SHALL implement FSM states TX_IDLE, TX_START, TX_DATA, TX_STOP.
REQ-013 In TX_IDLE with buffer non-empty, SHALL pop the head byte and enter TX_START at the next edge; with buffer empty, SHALL stay in TX_IDLE.
REQ-014 SHALL drive tx from a register: 1 in TX_IDLE and TX_STOP, 0 in TX_START, current data bit in TX_DATA.
REQ-015 SHALL hold each of start, data, stop bits for exactly CLKS_PER_BIT cycles via a bit-period counter of width $clog2(CLKS_PER_BIT), restarted at every bit boundary.
REQ-016 SHALL send NUM_DATA_BITS data bits LSB first, tracked by a bit index counting 0..NUM_DATA_BITS-1; frame = 1 start + 8 data + 1 stop = 10*CLKS_PER_BIT cycles.
REQ-017 Byte accepted at edge E into an empty buffer with FSM in TX_IDLE: tx SHALL be low starting at edge E+2 (E+1 pop, E+2 START register update).
REQ-018 At end of TX_STOP with buffer non-empty, SHALL pop and enter TX_START directly: zero idle cycles between frames.
REQ-019 At end of TX_STOP with buffer empty, SHALL return to TX_IDLE, tx remaining 1.
REQ-020 Simultaneous push and pop in one cycle SHALL leave count unchanged and preserve order.
REQ-021 Push when full SHALL not occur (tx_ready low); tx_data/tx_valid SHALL be ignored then; no overwrite.
REQ-022 busy SHALL be 1 whenever state != TX_IDLE or count != 0, else 0.
REQ-023 Changes on tx_data while tx_valid low SHALL have no effect.

Reset
REQ-024 On reset at edge, SHALL set state TX_IDLE, tx=1, bit counter=0, bit index=0, buffer count/pointers=0, hence tx_ready=1, busy=0.
REQ-025 Reset mid-frame SHALL abort the frame: tx=1 from the reset edge onward, buffered bytes discarded and never sent.
REQ-026 Reset SHALL dominate a simultaneous push; the byte is not stored.

Structure
REQ-027 SHALL take NUM_DATA_BITS and BAUD_COUNT_CHECK from package common; SHALL add typedef enum uart_tx_state_type {TX_IDLE, TX_START, TX_DATA, TX_STOP} to common.
REQ-028 SHALL instantiate one sub-module uart_tx_fifo (parameters WIDTH, DEPTH; push/pop, full/empty, count; same clk/reset); FSM and serializer stay in uart_tx.

Verification (CLKS_PER_BIT=4 for sim)
REQ-029 Push 0x55 when idle -> tx low from edge E+2, then 4-cycle bits 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop); busy drops after 40 cycles; tx stays 1.
REQ-030 Push 0xA5 then 0x3C on consecutive cycles -> two frames, 80 contiguous cycles, start of second frame immediately follows stop of first; data bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
REQ-031 During a frame, hold tx_valid with 0x01..0x05 -> 0x01..0x04 accepted, tx_ready=0 with 0x05 held until the next pop, then 0x05 accepted; all five sent in order.
REQ-032 Assert reset during data bit 3 of 0x0F with two bytes buffered -> tx=1, tx_ready=1, busy=0 after the reset edge; no further start bits appear.
REQ-033 One byte buffered, push arrives on the same edge the FSM pops at end of stop -> count stays 1; both bytes sent back-to-back in acceptance order.
REQ-034 Bench SHALL include a scoreboard sampling tx mid-bit and comparing decoded bytes against accepted bytes.
